// File: rtl/vmx_pkg.sv
// Shared constants and engine status encodings for the vmx matrix engine scratchpad.
package vmx_pkg;

    localparam int VMX_DEPTH  = 16;
    localparam int VMX_EAW    = 8;
    localparam int VMX_HAW    = $clog2(VMX_DEPTH) + 1;
    localparam int VMX_DW     = 64;
    localparam int VMX_LANE_W = 16;

    typedef enum logic [31:0] {
        FLAG_IDLE = 32'd0,
        FLAG_RD_A = 32'd1,
        FLAG_RD_B = 32'd2
    } eng_flag_e;

endpackage

// File: rtl/vmx_sp_host_if.sv
// Host request/grant port of the scratchpad: grant arbitration, read-pending flop,
// and the 32-bit half-word select/merge against a 64-bit entry.
module vmx_sp_host_if
    import vmx_pkg::*;
#(
    parameter int AW  = $clog2(VMX_DEPTH),
    parameter int HAW = VMX_HAW,
    parameter int DW  = VMX_DW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            h_req,
    input  logic            h_we,
    input  logic [HAW-1:0]  h_addr,
    input  logic [DW/2-1:0] h_wdata,
    input  logic            own,
    input  logic [DW-1:0]   cur_word,
    output logic            h_gnt,
    output logic            h_rvalid,
    output logic [DW/2-1:0] h_rdata,
    output logic [AW-1:0]   mem_idx,
    output logic            mem_we,
    output logic [DW-1:0]   mem_wdata
);

    localparam int HW = DW / 2;

    logic rd_pend;
    logic upper;

    // The engine always wins; a pending read response also blocks the next grant.
    assign h_gnt     = ~rst & h_req & ~own & ~rd_pend;
    assign upper     = h_addr[0];
    assign mem_idx   = h_addr[HAW-1:1];
    assign mem_we    = h_gnt & h_we;
    assign mem_wdata = upper ? {h_wdata, cur_word[HW-1:0]} : {cur_word[DW-1:HW], h_wdata};
    assign h_rvalid  = rd_pend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend <= 1'b0;
            h_rdata <= '0;
        end else begin
            rd_pend <= h_gnt & ~h_we;
            if (h_gnt & ~h_we) begin
                h_rdata <= upper ? cur_word[DW-1:HW] : cur_word[HW-1:0];
            end
        end
    end

endmodule

// File: rtl/vmx_mm_scratchpad.sv
// Operand/result scratchpad shared by the vmx_mm_wrapper engine port and a 32-bit host port,
// with sticky engine address error and an end-of-run interrupt pulse.
module vmx_mm_scratchpad
    import vmx_pkg::*;
#(
    parameter int DEPTH = VMX_DEPTH,
    parameter int EAW   = VMX_EAW,
    parameter int HAW   = VMX_HAW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [EAW-1:0] eng_addr,
    input  logic           eng_wr_en,
    input  logic [127:0]   eng_d_o,
    input  logic [31:0]    eng_flag,
    output logic [63:0]    eng_d_i,
    input  logic           h_req,
    input  logic           h_we,
    input  logic [HAW-1:0] h_addr,
    input  logic [31:0]    h_wdata,
    output logic           h_gnt,
    output logic           h_rvalid,
    output logic [31:0]    h_rdata,
    output logic           err,
    output logic           irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = VMX_DW;

    logic [DW-1:0] mem [DEPTH];
    logic          own;
    logic          rd_phase;
    logic          addr_bad;
    logic [AW-1:0] eng_idx;
    logic [AW-1:0] eng_idx_nxt;
    logic          busy_q;
    logic [AW-1:0] host_idx;
    logic          host_we;
    logic [DW-1:0] host_wdata;

    assign own         = (eng_flag != '0) | eng_wr_en;
    assign rd_phase    = (eng_flag == FLAG_RD_A) | (eng_flag == FLAG_RD_B);
    assign eng_idx     = eng_addr[AW-1:0];
    assign eng_idx_nxt = eng_idx + AW'(1);
    assign addr_bad    = |eng_addr[EAW-1:AW];
    assign eng_d_i     = rd_phase ? mem[eng_idx] : '0;
    assign irq         = busy_q & (eng_flag == '0);

    vmx_sp_host_if #(
        .AW  (AW),
        .HAW (HAW),
        .DW  (DW)
    ) u_host_if (
        .clk       (clk),
        .rst       (rst),
        .h_req     (h_req),
        .h_we      (h_we),
        .h_addr    (h_addr),
        .h_wdata   (h_wdata),
        .own       (own),
        .cur_word  (mem[host_idx]),
        .h_gnt     (h_gnt),
        .h_rvalid  (h_rvalid),
        .h_rdata   (h_rdata),
        .mem_idx   (host_idx),
        .mem_we    (host_we),
        .mem_wdata (host_wdata)
    );

    // Engine writes span two entries (the second wrapping at the top); host writes only
    // happen when the engine does not own memory, so the two never collide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (eng_wr_en && (AW'(i) == eng_idx)) begin
                    mem[i] <= eng_d_o[127:64];
                end else if (eng_wr_en && (AW'(i) == eng_idx_nxt)) begin
                    mem[i] <= eng_d_o[63:0];
                end else if (host_we && (AW'(i) == host_idx)) begin
                    mem[i] <= host_wdata;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err    <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            if (addr_bad && (rd_phase || eng_wr_en)) begin
                err <= 1'b1;
            end
            busy_q <= (eng_flag != '0);
        end
    end

endmodule

// File: tb/tb_vmx_mm_scratchpad.sv
// Randomized and directed bench for vmx_mm_scratchpad against an array-based reference model.
module tb_vmx_mm_scratchpad;

    logic         clk;
    logic         rst;
    logic [7:0]   eng_addr;
    logic         eng_wr_en;
    logic [127:0] eng_d_o;
    logic [31:0]  eng_flag;
    logic [63:0]  eng_d_i;
    logic         h_req;
    logic         h_we;
    logic [4:0]   h_addr;
    logic [31:0]  h_wdata;
    logic         h_gnt;
    logic         h_rvalid;
    logic [31:0]  h_rdata;
    logic         err;
    logic         irq;

    int vectors;
    int miscompares;

    logic [63:0] mMem [16];
    bit          mPend;
    bit          mErr;
    bit          mBusy;
    logic [31:0] mRdata;
    bit          lastGnt;
    int          irqSeen;

    logic        sGnt;
    logic        sRvalid;
    logic [31:0] sRdata;
    logic [63:0] sDi;
    logic        sErr;

    vmx_mm_scratchpad dut (
        .clk       (clk),
        .rst       (rst),
        .eng_addr  (eng_addr),
        .eng_wr_en (eng_wr_en),
        .eng_d_o   (eng_d_o),
        .eng_flag  (eng_flag),
        .eng_d_i   (eng_d_i),
        .h_req     (h_req),
        .h_we      (h_we),
        .h_addr    (h_addr),
        .h_wdata   (h_wdata),
        .h_gnt     (h_gnt),
        .h_rvalid  (h_rvalid),
        .h_rdata   (h_rdata),
        .err       (err),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] flag, input logic wr, input logic [7:0] addr,
                                 input logic [127:0] dataOut);
        eng_flag  = flag;
        eng_wr_en = wr;
        eng_addr  = addr;
        eng_d_o   = dataOut;
    endtask

    task automatic modelReset();
        for (int i = 0; i < 16; i++) mMem[i] = '0;
        mPend   = 0;
        mErr    = 0;
        mBusy   = 0;
        mRdata  = '0;
        lastGnt = 0;
    endtask

    // One clock: check every output against the model mid-cycle, then advance the model.
    task automatic runCycle();
        bit          ownNow;
        bit          readPhase;
        bit          expGnt;
        int          a;
        int          e;
        logic [63:0] expDi;
        @(negedge clk);
        ownNow    = (eng_flag != 0) || eng_wr_en;
        readPhase = (eng_flag == 1) || (eng_flag == 2);
        expGnt    = h_req && !ownNow && !mPend;
        a         = int'(eng_addr) % 16;
        e         = int'(h_addr) >> 1;
        expDi     = readPhase ? mMem[a] : 64'h0;
        sGnt = h_gnt; sRvalid = h_rvalid; sRdata = h_rdata; sDi = eng_d_i; sErr = err;
        checkOutput("h_gnt", h_gnt, expGnt);
        checkOutput("h_rvalid", h_rvalid, mPend);
        checkOutput("h_rdata", h_rdata, mRdata);
        checkOutput("eng_d_i", eng_d_i, expDi);
        checkOutput("err", err, mErr);
        checkOutput("irq", irq, mBusy && (eng_flag == 0));
        if (irq) irqSeen++;
        @(posedge clk);
        if (expGnt && !h_we) mRdata = h_addr[0] ? mMem[e][63:32] : mMem[e][31:0];
        if (eng_wr_en) begin
            mMem[a]            = eng_d_o[127:64];
            mMem[(a + 1) % 16] = eng_d_o[63:0];
        end else if (expGnt && h_we) begin
            if (h_addr[0]) mMem[e][63:32] = h_wdata;
            else           mMem[e][31:0]  = h_wdata;
        end
        mPend = expGnt && !h_we;
        if ((eng_addr >= 16) && (readPhase || eng_wr_en)) mErr = 1;
        mBusy   = (eng_flag != 0);
        lastGnt = expGnt;
        #1;
    endtask

    task automatic doReset();
        rst = 1;
        h_req = 1; h_we = 0; h_addr = '0; h_wdata = '0;
        applyStimulus(32'd0, 1'b0, 8'd0, '0);
        modelReset();
        repeat (2) @(negedge clk);
        checkOutput("rst_gnt", h_gnt, 0);
        checkOutput("rst_rvalid", h_rvalid, 0);
        checkOutput("rst_rdata", h_rdata, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_irq", irq, 0);
        h_req = 0;
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic hostOp(input logic we, input logic [4:0] addr, input logic [31:0] data);
        h_req = 1; h_we = we; h_addr = addr; h_wdata = data;
        for (int i = 0; i < 40; i++) begin
            runCycle();
            if (lastGnt) break;
        end
        h_req = 0;
        if (!lastGnt) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL host_timeout: got no grant expected grant within 40 cycles");
        end
    endtask

    initial begin
        int gntCount;
        int runLeft;
        int r;
        clk = 0; vectors = 0; miscompares = 0; irqSeen = 0;
        doReset();

        // Host write/read round trip
        hostOp(1'b1, 5'd1, 32'h00010000);
        hostOp(1'b1, 5'd0, 32'h00000000);
        hostOp(1'b0, 5'd1, 32'h0);
        runCycle();
        checkOutput("t1_rvalid", sRvalid, 1);
        checkOutput("t1_rdata", sRdata, 32'h00010000);
        runCycle();
        checkOutput("t1_rvalid_drop", sRvalid, 0);
        checkOutput("t1_rdata_hold", sRdata, 32'h00010000);

        // Combinational engine read
        hostOp(1'b1, 5'd4, 32'hFFFF0000);
        hostOp(1'b1, 5'd5, 32'h00000000);
        applyStimulus(32'd1, 1'b0, 8'd2, '0);
        runCycle();
        checkOutput("t2_rd", sDi, 64'h00000000FFFF0000);
        applyStimulus(32'd0, 1'b0, 8'd2, '0);
        runCycle();
        checkOutput("t2_idle", sDi, 64'h0);

        // Engine write wrapping at the top entry
        applyStimulus(32'd0, 1'b1, 8'd15, {64'hAAAAAAAAAAAAAAAA, 64'h5555555555555555});
        runCycle();
        applyStimulus(32'd1, 1'b0, 8'd15, '0);
        runCycle();
        checkOutput("t3_e15", sDi, 64'hAAAAAAAAAAAAAAAA);
        applyStimulus(32'd1, 1'b0, 8'd0, '0);
        runCycle();
        checkOutput("t3_e0", sDi, 64'h5555555555555555);
        applyStimulus(32'd0, 1'b0, 8'd0, '0);
        runCycle();
        checkOutput("t3_err", sErr, 0);

        // Host blocked during a run, granted at its end, one irq
        applyStimulus(32'd2, 1'b0, 8'd3, '0);
        h_req = 1; h_we = 0; h_addr = 5'd3;
        gntCount = 0;
        irqSeen = 0;
        for (int i = 0; i < 10; i++) begin
            runCycle();
            if (sGnt) gntCount++;
        end
        checkOutput("t4_blocked", gntCount, 0);
        applyStimulus(32'd0, 1'b0, 8'd0, '0);
        runCycle();
        checkOutput("t4_gnt", sGnt, 1);
        h_req = 0;
        repeat (3) runCycle();
        checkOutput("t4_irq_once", irqSeen, 1);

        // Out-of-range engine address
        applyStimulus(32'd1, 1'b0, 8'h12, '0);
        runCycle();
        checkOutput("t5_alias", sDi, 64'h00000000FFFF0000);
        applyStimulus(32'd0, 1'b0, 8'd0, '0);
        runCycle();
        checkOutput("t5_err", sErr, 1);

        // Randomized traffic
        runLeft = 0;
        for (int c = 0; c < 800; c++) begin
            if (runLeft == 0) begin
                eng_flag  = 32'd0;
                eng_wr_en = ($urandom_range(0, 9) == 0);
                if ($urandom_range(0, 7) == 0) runLeft = $urandom_range(2, 8);
            end else begin
                runLeft--;
                r = $urandom_range(0, 9);
                eng_flag  = (r < 4) ? 32'd1 : (r < 8) ? 32'd2 : (r < 9) ? 32'd3 : 32'h80000000;
                eng_wr_en = ($urandom_range(0, 3) == 0);
            end
            eng_addr = ($urandom_range(0, 29) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
            eng_d_o  = {$urandom, $urandom, $urandom, $urandom};
            if (!(h_req && !lastGnt)) begin
                h_req   = $urandom_range(0, 1);
                h_we    = $urandom_range(0, 1);
                h_addr  = 5'($urandom_range(0, 31));
                h_wdata = $urandom;
            end
            runCycle();
        end
        h_req = 0;
        applyStimulus(32'd0, 1'b0, 8'd0, '0);
        repeat (2) runCycle();

        // Reset the cycle after a read grant, and reset during an engine run
        hostOp(1'b0, 5'd2, 32'h0);
        doReset();
        applyStimulus(32'd1, 1'b0, 8'd2, '0);
        runCycle();
        doReset();
        applyStimulus(32'd1, 1'b0, 8'd2, '0);
        runCycle();
        checkOutput("t6_mem_clear", sDi, 64'h0);
        checkOutput("t6_rvalid", sRvalid, 0);
        applyStimulus(32'd0, 1'b0, 8'd0, '0);
        runCycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
